// File: rtl/fifo_rd_packer_if.sv
// rtl/fifo_rd_packer_if.sv - FIFO pop side and packed-word output of the read packer
interface fifo_rd_packer_if #(
  parameter int WIDTH = 8,
  parameter int PACK  = 4
);
  localparam int CW = $clog2(PACK) + 1;

  logic                    fifo_empty;
  logic [WIDTH-1:0]        fifo_rdata;
  logic                    fifo_rd_en;
  logic [WIDTH*PACK-1:0]   out_data;
  logic [CW-1:0]           out_nbytes;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    input  fifo_empty, fifo_rdata, out_ready,
    output fifo_rd_en, out_data, out_nbytes, out_valid
  );

  modport slave (
    output fifo_empty, fifo_rdata, out_ready,
    input  fifo_rd_en, out_data, out_nbytes, out_valid
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - pops FIFO bytes and packs them little-endian into words
module fifo_rd_packer #(
  parameter int WIDTH   = 8,
  parameter int PACK    = 4,
  parameter int IDLE_TO = 16
) (
  input  logic              rd_clk,
  input  logic              res,
  fifo_rd_packer_if.master  bus
);
  localparam int CW = $clog2(PACK) + 1;
  localparam int IW = (IDLE_TO > 1) ? $clog2(IDLE_TO) : 1;
  localparam logic [IW-1:0] IDLE_MAX = (IDLE_TO > 0) ? IW'(IDLE_TO - 1) : '0;

  typedef enum logic {FILL, EMIT} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic                  pend;
  logic                  rd_en, rd_en_nxt;
  logic                  to_fire;
  logic [IW-1:0]         idle;
  logic [WIDTH*PACK-1:0] data;
  logic [CW-1:0]         nbytes;
  logic [CW:0]           inflight;

  always_ff @(posedge rd_clk) begin
    if (res) state <= FILL;
    else     state <= state_nxt;
  end

  // Bytes already held plus those still in the pop pipeline bound new pops,
  // so a full word never overruns its slots.
  always_comb begin
    inflight  = {1'b0, cnt} + (CW+1)'(pend) + (CW+1)'(rd_en);
    to_fire   = (IDLE_TO != 0) && (state == FILL) && (cnt != '0) &&
                !pend && !rd_en && (idle == IDLE_MAX);
    rd_en_nxt = (state == FILL) && !bus.fifo_empty &&
                (inflight < (CW+1)'(PACK)) && !to_fire;
    state_nxt = state;
    case (state)
      FILL: if (cnt == CW'(PACK) || to_fire) state_nxt = EMIT;
      EMIT: if (bus.out_ready)               state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (res) begin
      cnt    <= '0;
      pend   <= 1'b0;
      rd_en  <= 1'b0;
      idle   <= '0;
      data   <= '0;
      nbytes <= '0;
    end else begin
      rd_en <= rd_en_nxt;
      pend  <= rd_en;
      if (state == EMIT) begin
        if (bus.out_ready) begin
          cnt    <= '0;
          idle   <= '0;
          data   <= '0;
          nbytes <= '0;
        end
      end else begin
        if (pend) begin
          for (int k = 0; k < PACK; k++)
            if (cnt == CW'(k)) data[k*WIDTH +: WIDTH] <= bus.fifo_rdata;
          cnt <= cnt + CW'(1);
        end
        if (pend || rd_en)
          idle <= '0;
        else if (cnt != '0 && idle != IDLE_MAX)
          idle <= idle + IW'(1);
        if (state_nxt == EMIT) nbytes <= cnt;
      end
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_data   = data;
  assign bus.out_nbytes = nbytes;
  assign bus.out_valid  = (state == EMIT);
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - directed bench for fifo_rd_packer with a byte-queue FIFO model
module tb_fifo_rd_packer;
  logic rd_clk = 1'b0;
  logic res;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_packer_if #(.WIDTH(8), .PACK(4)) a_if ();
  fifo_rd_packer_if #(.WIDTH(8), .PACK(4)) b_if ();

  fifo_rd_packer #(.WIDTH(8), .PACK(4), .IDLE_TO(8)) dut_a (
    .rd_clk (rd_clk),
    .res    (res),
    .bus    (a_if)
  );

  fifo_rd_packer #(.WIDTH(8), .PACK(4), .IDLE_TO(0)) dut_b (
    .rd_clk (rd_clk),
    .res    (res),
    .bus    (b_if)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]  q[$];
  logic [31:0] wq[$];
  logic [2:0]  nq[$];
  logic        gate;
  logic        prev_empty;
  logic        have_pop;
  logic [7:0]  pop_byte;
  int          viol;
  logic        underflow;
  int          cyc;
  int          t_rd, t_v;
  logic        b_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int i);
    return (wq.size() > i) ? wq[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic logic [2:0] nb_at(input int i);
    return (nq.size() > i) ? nq[i] : 3'd7;
  endfunction

  task automatic upd_empty();
    a_if.fifo_empty = gate || (q.size() == 0);
    b_if.fifo_empty = a_if.fifo_empty;
  endtask

  // One clock: record a handshake, advance, then play the FIFO.
  // A pop is charged at the edge that raised fifo_rd_en; its byte appears one cycle later.
  task automatic step();
    if (a_if.out_valid === 1'b1 && a_if.out_ready === 1'b1) begin
      wq.push_back(a_if.out_data);
      nq.push_back(a_if.out_nbytes);
    end
    prev_empty = a_if.fifo_empty;
    @(posedge rd_clk);
    #1;
    cyc++;
    a_if.fifo_rdata = have_pop ? pop_byte : 8'hEE;
    have_pop = 1'b0;
    if (a_if.fifo_rd_en === 1'b1) begin
      if (prev_empty) viol++;
      if (q.size() == 0) underflow = 1'b1;
      else begin
        pop_byte = q.pop_front();
        have_pop = 1'b1;
      end
    end
    b_if.fifo_rdata = a_if.fifo_rdata;
    upd_empty();
  endtask

  task automatic do_reset(input int n);
    res = 1'b1;
    repeat (n) step();
    res = 1'b0;
    wq.delete();
    nq.delete();
    have_pop  = 1'b0;
    viol      = 0;
    underflow = 1'b0;
  endtask

  task automatic load_seq(input logic [7:0] first, input int n, input logic [7:0] inc);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(first + 8'(i) * inc);
    upd_empty();
  endtask

  initial begin
    res = 1'b1;
    gate = 1'b0;
    cyc = 0;
    have_pop = 1'b0;
    pop_byte = 8'h00;
    a_if.fifo_rdata = 8'h00;
    b_if.fifo_rdata = 8'h00;
    a_if.out_ready = 1'b1;
    b_if.out_ready = 1'b1;

    // Reset with a non-empty FIFO
    load_seq(8'h11, 8, 8'h11);
    do_reset(3);
    check("rst_rd_en",  a_if.fifo_rd_en, 0);
    check("rst_valid",  a_if.out_valid,  0);
    check("rst_data",   a_if.out_data,   0);
    check("rst_nbytes", a_if.out_nbytes, 0);

    // Streaming 0x11..0x88
    t_rd = -1; t_v = -1;
    for (int i = 0; i < 60 && wq.size() < 2; i++) begin
      step();
      if (a_if.fifo_rd_en === 1'b1 && t_rd < 0) t_rd = cyc;
      if (a_if.out_valid === 1'b1 && t_v < 0) t_v = cyc;
    end
    check("s_words",   wq.size(), 2);
    check("s_latency", t_v - t_rd, 6);
    check("s_w0",      word_at(0), 32'h4433_2211);
    check("s_n0",      nb_at(0), 4);
    check("s_w1",      word_at(1), 32'h8877_6655);
    check("s_n1",      nb_at(1), 4);

    // Backpressure held for 10 cycles in EMIT
    a_if.out_ready = 1'b0;
    load_seq(8'h11, 8, 8'h11);
    do_reset(2);
    for (int i = 0; i < 40 && a_if.out_valid !== 1'b1; i++) step();
    check("bp_valid", a_if.out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_stable", a_if.out_data, 32'h4433_2211);
      check("bp_no_pop", a_if.fifo_rd_en, 0);
    end
    a_if.out_ready = 1'b1;
    step();
    check("bp_hs_valid", a_if.out_valid, 0);
    check("bp_hs_rd_en", a_if.fifo_rd_en, 0);
    step();
    check("bp_repop", a_if.fifo_rd_en, 1);
    for (int i = 0; i < 40 && wq.size() < 2; i++) step();
    check("bp_w0", word_at(0), 32'h4433_2211);
    check("bp_w1", word_at(1), 32'h8877_6655);

    // Flush of a partial word; dut_b (IDLE_TO=0) sees the same inputs
    q.delete();
    q.push_back(8'hAA);
    q.push_back(8'hBB);
    upd_empty();
    do_reset(2);
    t_rd = -1; t_v = -1; b_seen = 1'b0;
    for (int i = 0; i < 40 && a_if.out_valid !== 1'b1; i++) begin
      step();
      if (a_if.fifo_rd_en === 1'b1 && t_rd < 0) t_rd = cyc;
      if (a_if.out_valid === 1'b1) t_v = cyc;
      if (b_if.out_valid !== 1'b0) b_seen = 1'b1;
    end
    // last capture lands 3 edges after the first pop, flush 8 edges later
    check("fl_latency", t_v - t_rd, 11);
    check("fl_data",    a_if.out_data, 32'h0000_BBAA);
    check("fl_nbytes",  a_if.out_nbytes, 2);
    for (int i = 0; i < 12; i++) begin
      step();
      if (b_if.out_valid !== 1'b0) b_seen = 1'b1;
    end
    check("fl_off_no_emit", b_seen, 0);

    // Bursty empty over 12 bytes
    load_seq(8'h01, 12, 8'h01);
    do_reset(2);
    for (int i = 0; i < 200 && wq.size() < 3; i++) begin
      gate = ~gate;
      step();
    end
    gate = 1'b0;
    upd_empty();
    check("bu_w0", word_at(0), 32'h0403_0201);
    check("bu_w1", word_at(1), 32'h0807_0605);
    check("bu_w2", word_at(2), 32'h0C0B_0A09);
    check("bu_pop_when_empty", viol, 0);
    check("bu_underflow", underflow, 0);

    // Reset after two bytes captured
    q.delete();
    q.push_back(8'hA1);
    q.push_back(8'hA2);
    upd_empty();
    do_reset(2);
    repeat (5) step();
    res = 1'b1;
    step();
    res = 1'b0;
    wq.delete();
    nq.delete();
    load_seq(8'h01, 4, 8'h01);
    for (int i = 0; i < 40 && wq.size() < 1; i++) step();
    check("mr_data",   word_at(0), 32'h0403_0201);
    check("mr_nbytes", nb_at(0), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
